// File: rtl/fifo_wr_arbiter.sv
// Arbitrates NUM_REQ packet requesters onto a 2*BEAT_WIDTH FIFO write port, packing beats in pairs.
// Define FIFO_WR_ARB_STRICT_PRIO_EN for fixed lowest-index priority; default is round-robin.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BEAT_WIDTH = 144
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*BEAT_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [2*BEAT_WIDTH-1:0]       fifo_din,
    output logic                          fifo_wr_en,
    input  logic                          fifo_full,
    input  logic                          fifo_prog_full,
    output logic [2:0]                    grant_id,
    output logic                          busy
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t                  state, state_nxt;
    logic                    pending;
    logic                    half;
    logic [BEAT_WIDTH-1:0]   lo_beat;
    logic [2*BEAT_WIDTH-1:0] out_word;

    logic                    cur_valid;
    logic                    cur_last;
    logic [BEAT_WIDTH-1:0]   cur_data;
    logic                    can_take;
    logic                    accept;
    logic                    complete;
    logic                    any_sel;
    logic [2:0]              sel_id;
    logic                    grant;

    always_comb begin
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        cur_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == 3'(i)) begin
                cur_valid = req_valid[i];
                cur_last  = req_last[i];
                cur_data  = req_data[i*BEAT_WIDTH +: BEAT_WIDTH];
            end
        end
    end

    // A beat may land whenever the output register is free or is being written this cycle.
    assign can_take   = (state == XFER) && (!pending || !fifo_full) && !rst;
    assign accept     = can_take && cur_valid;
    assign complete   = accept && (half || cur_last);
    assign fifo_wr_en = pending && !fifo_full && !rst;
    assign fifo_din   = out_word;
    assign busy       = (state == XFER);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = can_take && (grant_id == 3'(i));
        end
    end

`ifdef FIFO_WR_ARB_STRICT_PRIO_EN
    always_comb begin
        any_sel = 1'b0;
        sel_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_sel = 1'b1;
                sel_id  = 3'(i);
            end
        end
    end
`else
    // Walk distances from farthest to nearest so the nearest requester after grant_id wins.
    always_comb begin
        any_sel = 1'b0;
        sel_id  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && (i == (int'(grant_id) + k) % NUM_REQ)) begin
                    any_sel = 1'b1;
                    sel_id  = 3'(i);
                end
            end
        end
    end
`endif

    assign grant = (state == IDLE) && any_sel && !fifo_prog_full && !pending;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (grant) state_nxt = XFER;
            XFER: if (accept && cur_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= 3'(NUM_REQ - 1);
            pending  <= 1'b0;
            half     <= 1'b0;
            lo_beat  <= '0;
            out_word <= '0;
        end else begin
            state <= state_nxt;
            if (grant) grant_id <= sel_id;
            if (accept) begin
                if (!half) begin
                    if (cur_last) out_word <= {{BEAT_WIDTH{1'b0}}, cur_data};
                    else          lo_beat  <= cur_data;
                    half <= !cur_last;
                end else begin
                    out_word <= {cur_data, lo_beat};
                    half     <= 1'b0;
                end
            end
            if (complete)        pending <= 1'b1;
            else if (fifo_wr_en) pending <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NUM_REQ=4, BEAT_WIDTH=144).
module tb_fifo_wr_arbiter;
    localparam int NR = 4;
    localparam int BW = 144;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NR-1:0]       req_valid = '0;
    logic [NR*BW-1:0]    req_data = '0;
    logic [NR-1:0]       req_last = '0;
    logic [NR-1:0]       req_ready;
    logic [2*BW-1:0]     fifo_din;
    logic                fifo_wr_en;
    logic                fifo_full = 1'b0;
    logic                fifo_prog_full = 1'b0;
    logic [2:0]          grant_id;
    logic                busy;

    fifo_wr_arbiter #(.NUM_REQ(NR), .BEAT_WIDTH(BW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .fifo_din(fifo_din),
        .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full), .fifo_prog_full(fifo_prog_full),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2*BW-1:0] wq[$];
    int              wc[$];
    always @(negedge clk) begin
        if (fifo_wr_en) begin
            wq.push_back(fifo_din);
            wc.push_back(cyc);
        end
    end

    int checks = 0;
    int errors = 0;
    int acc_cyc[8];

    task automatic check(input string tag, input logic [2*BW-1:0] got, input logic [2*BW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] beat(input int r, input int b);
        return {16'(r + 1), 112'h0, 16'(b + 1)};
    endfunction

    function automatic logic [2*BW-1:0] pair(input logic [BW-1:0] hi, input logic [BW-1:0] lo);
        return {hi, lo};
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        fifo_full = 1'b0;
        fifo_prog_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send(input int r, input int n, input bit term);
        int t;
        for (int b = 0; b < n; b++) begin
            @(negedge clk);
            req_valid[r] = 1'b1;
            req_data[r*BW +: BW] = beat(r, b);
            req_last[r] = term && (b == n - 1);
            #1;
            t = 0;
            while (!req_ready[r]) begin
                if (t >= 200) begin
                    check("send_timeout", 0, 1);
                    req_valid[r] = 1'b0;
                    return;
                end
                @(negedge clk);
                #1;
                t++;
            end
            acc_cyc[b] = cyc;
            @(posedge clk);
        end
        #1;
        req_valid[r] = 1'b0;
        req_last[r] = 1'b0;
    endtask

    task automatic exp_wr(input string tag, input logic [2*BW-1:0] e, output int c);
        int t = 0;
        c = -1;
        while (wq.size() == 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (wq.size() == 0) begin
            check({tag, "_none"}, 0, 1);
        end else begin
            check(tag, wq.pop_front(), e);
            c = wc.pop_front();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int t;
        int pk;
        bit bc[NR];
        logic [NR-1:0] rdy;
        int glog[$];

        // reset values
        reset_dut();
        @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_din", fifo_din, 0);
        check("rst_grant", grant_id, NR - 1);
        check("rst_busy", busy, 0);

        // 4-beat packet from requester 0
        send(0, 4, 1);
        exp_wr("a_w0", pair(beat(0, 1), beat(0, 0)), c);
        check("a_latency", c - acc_cyc[1], 1);
        exp_wr("a_w1", pair(beat(0, 3), beat(0, 2)), c);
        check("a_grant", grant_id, 0);

        // 3-beat packet from requester 1, odd tail zero-padded
        send(1, 3, 1);
        @(negedge clk);
        check("b_busy_fall", busy, 0);
        check("b_grant", grant_id, 1);
        exp_wr("b_w0", pair(beat(1, 1), beat(1, 0)), c);
        exp_wr("b_w1", pair('0, beat(1, 2)), c);

        // three requesters continuously valid with 2-beat packets
        reset_dut();
        for (int r = 0; r < NR; r++) bc[r] = 1'b0;
        pk = 0;
        t = 0;
        while (pk < 6 && t < 300) begin
            @(negedge clk);
            for (int r = 0; r < 3; r++) begin
                req_valid[r] = 1'b1;
                req_data[r*BW +: BW] = beat(r, int'(bc[r]));
                req_last[r] = bc[r];
            end
            #1 rdy = req_ready;
            @(posedge clk);
            for (int r = 0; r < 3; r++) begin
                if (rdy[r]) begin
                    if (bc[r]) begin
                        glog.push_back(r);
                        pk++;
                    end
                    bc[r] = !bc[r];
                end
            end
            t++;
        end
        #1;
        req_valid = '0;
        req_last = '0;
        check("rr_packets", pk, 6);
        for (int k = 0; k < glog.size(); k++) begin
`ifdef FIFO_WR_ARB_STRICT_PRIO_EN
            check("rr_order", glog[k], 0);
`else
            check("rr_order", glog[k], k % 3);
`endif
            exp_wr("rr_word", pair(beat(glog[k], 1), beat(glog[k], 0)), c);
        end

        // fifo_full stall with a pending word
        fifo_full = 1'b1;
        fork
            send(0, 4, 1);
            begin
                t = 0;
                @(negedge clk);
                while (!(busy && !req_ready[0]) && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 100) check("full_stall_timeout", 0, 1);
                for (int k = 0; k < 5; k++) begin
                    check("full_wr_en", fifo_wr_en, 0);
                    check("full_ready", req_ready, 0);
                    check("full_din", fifo_din, pair(beat(0, 1), beat(0, 0)));
                    if (k < 4) @(negedge clk);
                end
                @(posedge clk);
                #1 fifo_full = 1'b0;
                #1 check("full_release_wr", fifo_wr_en, 1);
            end
        join
        exp_wr("full_w0", pair(beat(0, 1), beat(0, 0)), c);
        exp_wr("full_w1", pair(beat(0, 3), beat(0, 2)), c);

        // prog_full blocks new grants
        @(negedge clk);
        fifo_prog_full = 1'b1;
        req_valid[2] = 1'b1;
        req_data[2*BW +: BW] = beat(2, 0);
        repeat (4) @(negedge clk);
        check("pf_busy", busy, 0);
        check("pf_ready", req_ready, 0);
        fifo_prog_full = 1'b0;
        send(2, 2, 1);
        exp_wr("pf_w0", pair(beat(2, 1), beat(2, 0)), c);

        // prog_full rising mid-packet does not stop it
        fork
            send(3, 4, 1);
            begin
                t = 0;
                while (!busy && t < 100) begin
                    @(posedge clk);
                    #1 t++;
                end
                fifo_prog_full = 1'b1;
            end
        join
        exp_wr("pfx_w0", pair(beat(3, 1), beat(3, 0)), c);
        exp_wr("pfx_w1", pair(beat(3, 3), beat(3, 2)), c);
        @(negedge clk);
        check("pfx_busy", busy, 0);
        fifo_prog_full = 1'b0;

        // reset with a held word: no write in or right after the reset cycle
        fifo_full = 1'b1;
        send(1, 2, 1);
        rst = 1'b1;
        fifo_full = 1'b0;
        #1 check("rstw_cycle_wr", fifo_wr_en, 0);
        @(posedge clk);
        @(negedge clk);
        check("rstw_after_wr", fifo_wr_en, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rstw_nowrite", wq.size(), 0);

        // reset after one beat of a packet
        send(0, 1, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rstp_ready", req_ready, 0);
        check("rstp_wr_en", fifo_wr_en, 0);
        check("rstp_din", fifo_din, 0);
        check("rstp_grant", grant_id, NR - 1);
        check("rstp_busy", busy, 0);
        rst = 1'b0;
        send(0, 2, 1);
        exp_wr("rstp_w0", pair(beat(0, 1), beat(0, 0)), c);
        repeat (3) @(negedge clk);
        check("final_extra_wr", wq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of packet requesters (2..8).
REQ-002 SHALL have parameter BEAT_WIDTH, default 144, width of one requester beat; FIFO word width is 2*BEAT_WIDTH.
REQ-003 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  NUM_REQ  per-requester beat valid.
REQ-006 SHALL have port req_data  input  NUM_REQ*BEAT_WIDTH  per-requester beat; requester i occupies slice [i*BEAT_WIDTH +: BEAT_WIDTH].
REQ-007 SHALL have port req_last  input  NUM_REQ  marks the final beat of a packet.
REQ-008 SHALL have port req_ready  output  NUM_REQ  beat accepted when req_valid[i] && req_ready[i].
REQ-009 SHALL have port fifo_din  output  2*BEAT_WIDTH  packed word to the width-converting FIFO write port.
REQ-010 SHALL have port fifo_wr_en  output  1  FIFO write strobe.
REQ-011 SHALL have ports fifo_full and fifo_prog_full  input  1 each  FIFO write-side status.
REQ-012 SHALL have port grant_id  output  3  index of the current or last granted requester.
REQ-013 SHALL have port busy  output  1  high while a packet is in transfer.

Function
REQ-014 SHALL implement FSM states IDLE and XFER.
REQ-015 IDLE: when any req_valid is high and fifo_prog_full is low, SHALL register the grant, load grant_id, and enter XFER on the next cycle; otherwise SHALL remain in IDLE.
REQ-016 Grant selection SHALL be round-robin, searching from grant_id+1 upward with wrap to 0; the first grant after reset SHALL search from requester 0.
REQ-017 A grant SHALL hold for a whole packet; no switching occurs until the last beat is accepted.
REQ-018 req_ready[i] SHALL be high only in XFER for i == grant_id, and only when the output register is empty or fifo_full is low; all other bits SHALL be 0.
REQ-019 Beats SHALL be packed in pairs: first beat to fifo_din[BEAT_WIDTH-1:0], second beat to the upper half.
REQ-020 A word SHALL complete on the second beat, or on a last beat that lands in the lower half, in which case the upper half SHALL be all zeros.
REQ-021 A completed word SHALL be held in an output register; fifo_wr_en SHALL be output_pending && !fifo_full; pending SHALL clear on the write.
REQ-022 Latency SHALL be one cycle from the completing beat acceptance to fifo_wr_en, when fifo_full is low.
REQ-023 A completed word and the next accepted beat in the same cycle SHALL both be handled without loss or duplication.
REQ-024 When the last beat is accepted, the FSM SHALL return to IDLE and busy SHALL fall on the next cycle; the held word SHALL still drain.
REQ-025 IDLE SHALL NOT grant while output_pending is set.
REQ-026 fifo_prog_full SHALL gate only new grants; an in-progress packet continues until fifo_full.
REQ-027 fifo_din SHALL remain stable while fifo_wr_en is low and pending is set.

Reset
REQ-028 On rst, the block SHALL set: state=IDLE, req_ready=0, fifo_wr_en=0, fifo_din=0, grant_id=NUM_REQ-1, busy=0, pending=0, half=0.
REQ-029 A reset mid-packet SHALL discard the partial word and the held word; no write SHALL occur in the reset cycle or in the cycle that follows.

Configuration
REQ-030 With macro FIFO_WR_ARB_STRICT_PRIO_EN defined, grant selection SHALL be fixed priority, with the lowest index winning.
REQ-031 Without FIFO_WR_ARB_STRICT_PRIO_EN, the block SHALL use the round-robin selection of REQ-016.

Verification
REQ-032 Single requester 0, 4-beat packet A0..A3, FIFO idle -> two writes {A1,A0} and {A3,A2}; the first write occurs 1 cycle after A1 is accepted.
REQ-033 Requester 1, 3-beat packet B0..B2 -> writes {B1,B0} then {0,B2}; busy falls after B2 is accepted.
REQ-034 Requesters 0, 1 and 2 each continuously valid with 2-beat packets -> grant order 0,1,2,0,...; with FIFO_WR_ARB_STRICT_PRIO_EN defined -> always 0.
REQ-035 fifo_full is held high for 5 cycles while a word is pending -> fifo_din is stable, req_ready is low, no beat is lost, and the write occurs on the first cycle fifo_full is low.
REQ-036 fifo_prog_full is high while in IDLE with requests pending -> no grant; the current packet completes if prog_full rises during XFER.
REQ-037 rst is asserted after 1 beat of a packet -> all outputs are at reset values, and the next packet after reset is packed from the lower half.
